conv_layer_ctrl: RTL

Sequencer for a bank of NUM_CONV convolution engines that share one input frame.
- Accepts a frame of samples from upstream over a valid/ready handshake and buffers it.
- Replays the frame to all engines as a start pulse plus a word burst, then waits for every engine to report done.
- Serializes all engine results downstream over valid/yumi, then releases the engines.
- Sits between the input sample stream and the first convolutional layer.

---
 rtl/conv_layer_ctrl_pkg.sv | 25 ++
 rtl/conv_layer_ctrl_if.sv | 36 +++
 rtl/conv_layer_ctrl_frame_buffer.sv | 28 ++
 rtl/conv_layer_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/conv_layer_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution layer sequencer and its engines.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    eLOAD    = 3'd0,
    eRUN     = 3'd1,
    eWAIT    = 3'd2,
    eDRAIN   = 3'd3,
    eRELEASE = 3'd4
  } state_e;

  function automatic int frame_words(input int layer_height, input int kernel_width);
    return layer_height * kernel_width;
  endfunction

  function automatic int num_out(input int layer_height, input int kernel_height);
    return layer_height - kernel_height + 1;
  endfunction

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/conv_layer_ctrl_if.sv
// Upstream sample stream, engine broadcast/collect and downstream result signals.
// Names carry the controller's point of view; master is the controller side.
interface conv_layer_ctrl_if #(
  parameter int NUM_CONV  = 2,
  parameter int NUM_OUT   = 2,
  parameter int WORD_SIZE = 16
);

  logic                                  valid_i;
  logic [WORD_SIZE-1:0]                  data_i;
  logic                                  ready_o;
  logic                                  conv_start_o;
  logic [WORD_SIZE-1:0]                  conv_data_o;
  logic                                  conv_data_valid_o;
  logic [NUM_CONV-1:0]                   conv_valid_i;
  logic [NUM_CONV*NUM_OUT*WORD_SIZE-1:0] conv_data_i;
  logic                                  conv_yumi_o;
  logic                                  valid_o;
  logic [WORD_SIZE-1:0]                  data_o;
  logic                                  last_o;
  logic                                  yumi_i;
  logic                                  error_o;

  modport master (
    input  valid_i, data_i, conv_valid_i, conv_data_i, yumi_i,
    output ready_o, conv_start_o, conv_data_o, conv_data_valid_o,
           conv_yumi_o, valid_o, data_o, last_o, error_o
  );

  modport slave (
    output valid_i, data_i, conv_valid_i, conv_data_i, yumi_i,
    input  ready_o, conv_start_o, conv_data_o, conv_data_valid_o,
           conv_yumi_o, valid_o, data_o, last_o, error_o
  );

endinterface

// File: rtl/conv_layer_ctrl_frame_buffer.sv
// Frame store: one write port, one combinational read port, cleared by reset.
module frame_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_layer_ctrl.sv
// Buffers one input frame, replays it to all conv engines, then drains their results.
//   state    | meaning
//   eLOAD    | accept FRAME_WORDS samples from upstream into the buffer
//   eRUN     | start pulse, then one buffered word per cycle to the engines
//   eWAIT    | wait for every engine done; timeout sets error and releases
//   eDRAIN   | serialize NUM_RESULTS words downstream over valid/yumi
//   eRELEASE | one-cycle release pulse to the engines
module conv_layer_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int NUM_CONV           = 2,
  parameter int INPUT_LAYER_HEIGHT = 4,
  parameter int KERNEL_HEIGHT      = 3,
  parameter int KERNEL_WIDTH       = 2,
  parameter int WORD_SIZE          = 16,
  parameter int TIMEOUT            = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  conv_layer_ctrl_if.master bus
);

  localparam int FRAME_WORDS = frame_words(INPUT_LAYER_HEIGHT, KERNEL_WIDTH);
  localparam int NUM_OUT     = num_out(INPUT_LAYER_HEIGHT, KERNEL_HEIGHT);
  localparam int NUM_RESULTS = NUM_CONV * NUM_OUT;
  localparam int LW          = cnt_w(FRAME_WORDS - 1);
  localparam int RW          = cnt_w(FRAME_WORDS);
  localparam int WW          = cnt_w(TIMEOUT);
  localparam int DW          = cnt_w(NUM_RESULTS - 1);

  state_e         state_q, state_d;
  logic [LW-1:0]  load_cnt_q, load_cnt_d;
  logic [RW-1:0]  run_cnt_q, run_cnt_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]  res_cnt_q, res_cnt_d;
  logic           error_q, error_d;

  logic           ready;
  logic           conv_start;
  logic           conv_data_valid;
  logic           conv_yumi;
  logic           valid;
  logic           last;
  logic           buf_we;
  logic [LW-1:0]  rd_addr;
  logic [WORD_SIZE-1:0] rd_data;
  logic [WORD_SIZE-1:0] res_words [NUM_RESULTS];

  for (genvar r = 0; r < NUM_RESULTS; r++) begin : g_res
    assign res_words[r] = bus.conv_data_i[r*WORD_SIZE +: WORD_SIZE];
  end

  // Run cycle k (k >= 1) presents buffer word k-1.
  assign rd_addr = LW'(run_cnt_q - RW'(1));

  frame_buffer #(
    .DEPTH (FRAME_WORDS),
    .WIDTH (WORD_SIZE),
    .AW    (LW)
  ) u_frame_buffer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (buf_we),
    .waddr_i (load_cnt_q),
    .wdata_i (bus.data_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= eLOAD;
      load_cnt_q <= '0;
      run_cnt_q  <= '0;
      wait_cnt_q <= '0;
      res_cnt_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      run_cnt_q  <= run_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      res_cnt_q  <= res_cnt_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    load_cnt_d      = load_cnt_q;
    run_cnt_d       = run_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    res_cnt_d       = res_cnt_q;
    error_d         = error_q;
    ready           = 1'b0;
    conv_start      = 1'b0;
    conv_data_valid = 1'b0;
    conv_yumi       = 1'b0;
    valid           = 1'b0;
    last            = 1'b0;
    buf_we          = 1'b0;

    case (state_q)
      eLOAD: begin
        ready = 1'b1;
        if (bus.valid_i) begin
          buf_we = 1'b1;
          if (load_cnt_q == LW'(FRAME_WORDS - 1)) begin
            load_cnt_d = '0;
            state_d    = eRUN;
          end else begin
            load_cnt_d = load_cnt_q + LW'(1);
          end
        end
      end

      eRUN: begin
        if (run_cnt_q == '0) conv_start = 1'b1;
        else                 conv_data_valid = 1'b1;
        if (run_cnt_q == RW'(FRAME_WORDS)) begin
          run_cnt_d  = '0;
          wait_cnt_d = '0;
          state_d    = eWAIT;
        end else begin
          run_cnt_d = run_cnt_q + RW'(1);
        end
      end

      eWAIT: begin
        if (&bus.conv_valid_i) begin
          wait_cnt_d = '0;
          res_cnt_d  = '0;
          state_d    = eDRAIN;
        end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
          // The TIMEOUT-th idle cycle: give up on this frame and free the engines.
          error_d    = 1'b1;
          conv_yumi  = 1'b1;
          wait_cnt_d = '0;
          state_d    = eLOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end

      eDRAIN: begin
        valid = 1'b1;
        last  = (res_cnt_q == DW'(NUM_RESULTS - 1));
        if (bus.yumi_i) begin
          if (last) begin
            res_cnt_d = '0;
            state_d   = eRELEASE;
          end else begin
            res_cnt_d = res_cnt_q + DW'(1);
          end
        end
      end

      eRELEASE: begin
        conv_yumi = 1'b1;
        state_d   = eLOAD;
      end

      default: state_d = eLOAD;
    endcase
  end

  assign bus.ready_o           = ready;
  assign bus.conv_start_o      = conv_start;
  assign bus.conv_data_valid_o = conv_data_valid;
  assign bus.conv_data_o       = conv_data_valid ? rd_data : '0;
  assign bus.conv_yumi_o       = conv_yumi;
  assign bus.valid_o           = valid;
  assign bus.last_o            = last;
  assign bus.data_o            = valid ? res_words[res_cnt_q] : '0;
  assign bus.error_o           = error_q;

endmodule
